// File: rtl/data_cache.sv
// Direct-mapped, write-through, read-allocate data cache with one-word lines.
// Optional hit/miss counters enabled by defining DATA_CACHE_STATS_EN.
module data_cache #(
   parameter int DATA_WIDTH = 32,
   parameter int INDEX_BITS = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_i,
   input  logic                  we_i,
   input  logic [2:0]            mem_ctrl_i,
   input  logic [DATA_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  stall_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [DATA_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   output logic [3:0]            mem_wstrb_o,
   input  logic                  mem_ack_i,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
`ifdef DATA_CACHE_STATS_EN
   ,
   output logic [31:0]           hits_o,
   output logic [31:0]           misses_o
`endif
);

   localparam int TAG_BITS = DATA_WIDTH - INDEX_BITS - 2;
   localparam int LINES    = 1 << INDEX_BITS;

   typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

   state_t                state;
   logic [LINES-1:0]      valid;
   logic [TAG_BITS-1:0]   tag_mem  [LINES];
   logic [DATA_WIDTH-1:0] data_mem [LINES];

   logic [INDEX_BITS-1:0] idx, lat_idx;
   logic [TAG_BITS-1:0]   tag, lat_tag;
   logic [DATA_WIDTH-1:0] word;
   logic                  hit, load, store, lat_hit;
   logic [7:0]            byte_sel;
   logic [15:0]           half_sel;
   logic [DATA_WIDTH-1:0] wdata_next;
   logic [3:0]            wstrb_next;

   assign idx      = addr_i[INDEX_BITS+1:2];
   assign tag      = addr_i[DATA_WIDTH-1:INDEX_BITS+2];
   assign word     = data_mem[idx];
   assign hit      = valid[idx] && (tag_mem[idx] == tag);
   assign load     = (state == IDLE) && req_i && !we_i;
   assign store    = (state == IDLE) && req_i && we_i;
   assign byte_sel = word[{addr_i[1:0], 3'b000} +: 8];
   assign half_sel = word[{addr_i[1], 4'b0000} +: 16];

   // The latched request lives in the mem_* registers; the write merge reuses them.
   assign lat_idx  = mem_addr_o[INDEX_BITS+1:2];
   assign lat_tag  = mem_addr_o[DATA_WIDTH-1:INDEX_BITS+2];
   assign lat_hit  = valid[lat_idx] && (tag_mem[lat_idx] == lat_tag);

   always_comb begin
      data_o = '0;
      if (load && hit) begin
         case (mem_ctrl_i)
            3'b000:  data_o = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            3'b001:  data_o = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            3'b100:  data_o = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            3'b101:  data_o = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default: data_o = word;
         endcase
      end
   end

   always_comb begin
      wdata_next = data_i;
      wstrb_next = 4'b1111;
      case (mem_ctrl_i)
         3'b000, 3'b100: begin
            wstrb_next = 4'b0001 << addr_i[1:0];
            wdata_next = DATA_WIDTH'(data_i[7:0]) << {addr_i[1:0], 3'b000};
         end
         3'b001, 3'b101: begin
            wstrb_next = 4'b0011 << {addr_i[1], 1'b0};
            wdata_next = DATA_WIDTH'(data_i[15:0]) << {addr_i[1], 4'b0000};
         end
         default: ;
      endcase
   end

   always_comb begin
      stall_o = 1'b0;
      case (state)
         IDLE:    stall_o = store || (load && !hit);
         FILL:    stall_o = 1'b1;
         WRITE:   stall_o = !mem_ack_i;
         default: stall_o = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         valid       <= '0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         mem_wstrb_o <= '0;
`ifdef DATA_CACHE_STATS_EN
         hits_o      <= '0;
         misses_o    <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (store) begin
                  state       <= WRITE;
                  mem_req_o   <= 1'b1;
                  mem_we_o    <= 1'b1;
                  mem_addr_o  <= {addr_i[DATA_WIDTH-1:2], 2'b00};
                  mem_wdata_o <= wdata_next;
                  mem_wstrb_o <= wstrb_next;
               end else if (load && !hit) begin
                  state       <= FILL;
                  mem_req_o   <= 1'b1;
                  mem_we_o    <= 1'b0;
                  mem_addr_o  <= {addr_i[DATA_WIDTH-1:2], 2'b00};
                  mem_wdata_o <= '0;
                  mem_wstrb_o <= '0;
               end
`ifdef DATA_CACHE_STATS_EN
               if (load && hit)  hits_o   <= hits_o + 32'd1;
               if (load && !hit) misses_o <= misses_o + 32'd1;
`endif
            end
            FILL: begin
               if (mem_ack_i) begin
                  state          <= IDLE;
                  mem_req_o      <= 1'b0;
                  valid[lat_idx] <= 1'b1;
               end
            end
            WRITE: begin
               if (mem_ack_i) begin
                  state       <= IDLE;
                  mem_req_o   <= 1'b0;
                  mem_we_o    <= 1'b0;
                  mem_wstrb_o <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Line storage carries no reset; the valid bits alone qualify it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == FILL && mem_ack_i) begin
            tag_mem[lat_idx]  <= lat_tag;
            data_mem[lat_idx] <= mem_rdata_i;
         end else if (state == WRITE && mem_ack_i && lat_hit) begin
            for (int unsigned b = 0; b < 4; b++) begin
               if (mem_wstrb_o[b]) data_mem[lat_idx][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-through, read-allocate data cache: the responder to the pipeline's load/store interface in the cached core variant, sitting between the execute-stage memory request and the backing main-memory port. It serves load hits combinationally, stalls the pipeline on load misses while filling a one-word line, and forwards every store to memory with byte strobes. Byte/half/word sizing follows the RISC-V funct3 encoding on `mem_ctrl`.

## Interface
- `DATA_WIDTH`, 32, data and address width (only 32 supported)
- `INDEX_BITS`, 6, log2 of number of lines (64 one-word lines)
- `clk` in 1, rising-edge clock
- `rst` in 1, reset, synchronous, active-high
- `req_i` in 1, CPU access valid
- `we_i` in 1, 1 = store, 0 = load
- `mem_ctrl_i` in 3, funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `addr_i` in 32, byte address
- `data_i` in 32, store data (right-aligned)
- `data_o` out 32, load result, sign/zero-extended
- `stall_o` out 1, pipeline hold
- `mem_req_o` out 1, backing-memory request
- `mem_we_o` out 1, backing write
- `mem_addr_o` out 32, word-aligned address (bits [1:0] = 0)
- `mem_wdata_o` out 32, lane-shifted store data
- `mem_wstrb_o` out 4, byte enables
- `mem_ack_i` in 1, one-cycle completion
- `mem_rdata_i` in 32, fill word, valid with ack

## Operation
- Address split: offset [1:0], index [INDEX_BITS+1:2], tag [31:INDEX_BITS+2]. Storage: valid bit, tag, 32-bit word per line.
- Alignment: H ignores addr[0]; W ignores addr[1:0]. No misalign trap.
- States: IDLE, FILL, WRITE.
- IDLE, no req: stall_o=0, mem_req_o=0.
- IDLE, load hit: data_o extracted from cached word same cycle, stall_o=0, stay IDLE.
- IDLE, load miss: stall_o=1 combinationally; -> FILL.
- FILL: mem_req_o=1, mem_we_o=0, mem_addr_o=word address; held until mem_ack_i. On ack: write word, set valid, write tag; -> IDLE. The pipeline replays and hits next cycle.
- IDLE, store: stall_o=1; -> WRITE.
- WRITE: mem_req_o=1, mem_we_o=1, wstrb B = 0001<<off, H = 0011<<{off[1],0}, W = 1111; wdata replicated/shifted into lanes. On ack: if line valid and tag matches, merge strobed bytes into cached word; miss does not allocate; -> IDLE with stall_o=0 that cycle.
- Store and load request inputs are held stable by the pipeline while stall_o=1; the cache latches address/data on leaving IDLE.
- mem_ack_i in IDLE is ignored.
- Undefined funct3 (011, 110, 111) treated as W.

## Timing
- Reset: all valid bits cleared, state IDLE; data_o=0, stall_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, mem_wstrb_o=0.
- Load hit: 0 extra cycles. Load miss: 1 + N cycles stalled, where N is the ack latency (≥1), plus the replay hit.
- Store: stall_o high from request cycle until the ack cycle inclusive of FILL/WRITE state; stall_o deasserts in the ack cycle.
- mem_* outputs registered, stable while mem_req_o=1.
- rst mid-FILL/WRITE: return to IDLE next edge, mem_req_o=0, no line written, late ack ignored.
- Ack and rst in the same cycle: reset wins, no update.

## Configuration
- `DATA_CACHE_STATS_EN` defined: adds outputs `hits_o` [31:0], `misses_o` [31:0]. A load hit in IDLE increments hits. A load miss increments misses once on entry to FILL. Counts are cleared by rst and wrap at 2^32.
- `DATA_CACHE_STATS_EN` undefined: the ports and counters are absent.

## Test plan
- Post-reset LW 0x100 -> stall until ack. mem_addr_o=0x100, mem_rdata_i=0xDEADBEEF. The replay returns data_o=0xDEADBEEF with stall_o=0.
- After that fill, LB 0x103 -> data_o=0xFFFFFFDE, LBU 0x103 -> 0x000000DE, LH 0x102 -> 0xFFFFDEAD, LHU 0x100 -> 0x0000BEEF, all 0-stall.
- SB 0x101 data 0x55 on a cached line -> mem_wstrb_o=0010, mem_wdata_o=0x00005500. The next LW 0x100 hits and returns 0xDEAD55EF.
- SW 0x200 on an uncached line -> write issued, then LW 0x200 misses (no allocate).
- Alias: fill 0x100, then LW 0x200 (same index, tag differs) -> miss and refill. A later LW 0x100 misses again.
- Assert rst during FILL with ack one cycle later -> no valid bit set. A subsequent LW of the same address misses. With stats enabled, the counters read 0 after reset.
